fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared constants and types for the instruction fetch unit.
//   XLEN        : address/data width
//   PC_STEP     : byte distance between consecutive fetch addresses
//   FETCH_DEPTH : credit limit on requests in flight plus buffered words
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : {pc, instruction} pair held in the output buffer
package fetch_pkg;

   localparam int XLEN        = 32;
   localparam int PC_STEP     = 4;
   localparam int FETCH_DEPTH = 2;
   localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);
   localparam int PTR_W       = $clog2(FETCH_DEPTH);

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      STALL
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } fetch_entry_t;

   // Clear the sub-word offset bits of a byte address.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~XLEN'(PC_STEP - 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- small in-order output buffer of fetched {pc, instruction} pairs.
//   clk, reset (async, active low)
//   flush     : drop all entries (wins over push/pop)
//   push      : write push_data at the tail
//   pop       : retire the head entry
//   not_empty : head is valid
//   head      : oldest entry (all-zero after reset)
//   count     : number of entries held
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output logic             not_empty,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem [FETCH_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_push = push && ((count != CNT_W'(FETCH_DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FETCH_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   assign head      = mem[rd_ptr];
   assign not_empty = (count != '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetch with credit flow control and
// redirect handling.
//   clk, reset (async, active low)
//   imem_req_valid/addr/ready : fetch request channel (word-aligned address)
//   imem_rsp_valid/data       : in-order responses, one per accepted request
//   redirect_valid/pc         : single-cycle branch/jump redirect
//   inst_valid/data/pc/ready  : instruction stream to decode
// Credits cover requests in flight plus buffered words, so a response always
// finds room in the output buffer. After a redirect, responses to requests
// issued before it are counted off and dropped.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
);

   localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FETCH_DEPTH);

   fetch_state_e     state;
   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  tag_q [FETCH_DEPTH];
   logic [PTR_W-1:0] tag_wr;
   logic [PTR_W-1:0] tag_rd;
   logic [CNT_W-1:0] in_flight;
   logic [CNT_W-1:0] in_flight_n;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] discard_n;
   logic [CNT_W-1:0] buf_count;
   logic [CNT_W-1:0] buf_count_n;
   logic             buf_not_empty;
   fetch_entry_t     buf_head;
   fetch_entry_t     buf_push_data;
   logic             req_fire;
   logic             rsp_fire;
   logic             rsp_keep;
   logic             pop;
   logic             full_n;

   // The FSM state already encodes "credits available"; redirect only masks.
   assign imem_req_valid = (state == FETCH) && !redirect_valid;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is ignored rather than underflowing.
   assign rsp_fire = imem_rsp_valid && (in_flight != '0);
   assign rsp_keep = rsp_fire && !redirect_valid && (discard == '0);

   assign inst_valid = buf_not_empty && !redirect_valid;
   assign pop        = inst_valid && inst_ready;
   assign inst_data  = buf_head.data;
   assign inst_pc    = buf_head.pc;

   assign buf_push_data = '{pc: tag_q[tag_rd], data: imem_rsp_data};

   fetch_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data (buf_push_data),
      .pop       (pop),
      .not_empty (buf_not_empty),
      .head      (buf_head),
      .count     (buf_count)
   );

   // Next-cycle occupancy, used to pick FETCH/STALL one cycle ahead so the
   // request valid comes straight from a register.
   always_comb begin
      in_flight_n = in_flight;
      if (req_fire && !rsp_fire)      in_flight_n = in_flight + CNT_W'(1);
      else if (!req_fire && rsp_fire) in_flight_n = in_flight - CNT_W'(1);

      buf_count_n = buf_count;
      if (redirect_valid)             buf_count_n = '0;
      else if (rsp_keep && !pop)      buf_count_n = buf_count + CNT_W'(1);
      else if (!rsp_keep && pop)      buf_count_n = buf_count - CNT_W'(1);

      // Everything still outstanding after a redirect belongs to the old path.
      discard_n = discard;
      if (redirect_valid)                     discard_n = in_flight_n;
      else if (rsp_fire && (discard != '0))   discard_n = discard - CNT_W'(1);

      full_n = ({1'b0, in_flight_n} + {1'b0, buf_count_n}) >= DEPTH_LIM;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= BOOT;
      end else begin
         case (state)
            BOOT:    state <= FETCH;
            default: state <= full_n ? STALL : FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc  <= RESET_PC;
         for (int i = 0; i < FETCH_DEPTH; i++) tag_q[i] <= '0;
         tag_wr    <= '0;
         tag_rd    <= '0;
         in_flight <= '0;
         discard   <= '0;
      end else begin
         in_flight <= in_flight_n;
         discard   <= discard_n;
         if (req_fire) begin
            tag_q[tag_wr] <= fetch_pc;
            tag_wr        <= tag_wr + PTR_W'(1);
         end
         // Tags of dropped responses retire too, keeping the queue aligned.
         if (rsp_fire) tag_rd <= tag_rd + PTR_W'(1);
         if (redirect_valid) fetch_pc <= align_pc(redirect_pc);
         else if (req_fire)  fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data, inst_pc;

   logic        req_valid2, rsp_valid2, inst_valid2;
   logic [31:0] req_addr2, rsp_data2, inst_data2, inst_pc2;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   // Second instance only exercises the wrap-around start address.
   fetch_unit #(.RESET_PC(RST_PC2)) dut2 (
      .clk(clk), .reset(reset),
      .imem_req_valid(req_valid2), .imem_req_addr(req_addr2), .imem_req_ready(1'b1),
      .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .inst_valid(inst_valid2), .inst_data(inst_data2), .inst_pc(inst_pc2), .inst_ready(1'b1)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: architectural fetch PC, list of outstanding requests
   // (which is also the memory's pending list), number of oldest outstanding
   // requests belonging to a cancelled path, and the buffered instructions.
   longint      cyc;
   logic [31:0] m_pc;
   bit          m_boot;
   int          m_stale;
   logic [31:0] mem_addr[$];
   longint      mem_due[$];
   logic [31:0] buf_pc[$], buf_data[$];

   logic [31:0] acc_log[$], pop_pc_log[$], pop_data_log[$], acc2_log[$];
   longint      acc_cyc[$];
   bit          pend2;
   logic [31:0] pend2_addr;

   int p_ready, p_iready, p_redir, p_rsp, lat_max;
   bit force_redir;
   logic [31:0] force_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
   endfunction

   function automatic bit roll(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic knobs(input int r, input int ir, input int rd, input int rs, input int lm);
      p_ready = r; p_iready = ir; p_redir = rd; p_rsp = rs; lat_max = lm;
   endtask

   task automatic drive_idle();
      imem_req_ready = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
      imem_rsp_valid = 0; imem_rsp_data = 0; rsp_valid2 = 0; rsp_data2 = 0;
   endtask

   task automatic clear_model();
      m_pc = RST_PC; m_boot = 1; m_stale = 0; cyc = 0;
      mem_addr.delete(); mem_due.delete(); buf_pc.delete(); buf_data.delete();
      acc_log.delete(); acc_cyc.delete(); pop_pc_log.delete(); pop_data_log.delete();
      acc2_log.delete(); pend2 = 0; pend2_addr = 0;
   endtask

   // Entered just after a rising edge; asserts reset mid-cycle and checks the
   // outputs respond before any further clock edge.
   task automatic apply_reset();
      drive_idle();
      #2 reset = 1'b0;
      #1;
      chk("rst_req_valid",  imem_req_valid, 0);
      chk("rst_req_addr",   imem_req_addr, RST_PC);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst_data",  inst_data, 0);
      chk("rst_inst_pc",    inst_pc, 0);
      chk("rst_req_addr2",  req_addr2, RST_PC2);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      clear_model();
   endtask

   task automatic step();
      bit          exp_rv, exp_iv, acc, pop;
      logic [31:0] a;
      imem_req_ready = roll(p_ready);
      inst_ready     = roll(p_iready);
      redirect_valid = force_redir || roll(p_redir);
      redirect_pc    = force_redir ? force_pc : $urandom();
      if (mem_addr.size() != 0 && mem_due[0] <= cyc && roll(p_rsp)) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_addr[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom();
      end
      rsp_valid2 = pend2;
      rsp_data2  = mem_word(pend2_addr);

      @(negedge clk);
      exp_rv = !m_boot && (mem_addr.size() + buf_pc.size() < 2) && !redirect_valid;
      exp_iv = (buf_pc.size() != 0) && !redirect_valid;
      chk("req_valid",  imem_req_valid, exp_rv);
      chk("req_addr",   imem_req_addr, m_pc);
      chk("inst_valid", inst_valid, exp_iv);
      if (exp_iv) begin
         chk("inst_pc",   inst_pc, buf_pc[0]);
         chk("inst_data", inst_data, buf_data[0]);
      end

      if (imem_req_valid && imem_req_ready) begin
         acc_log.push_back(imem_req_addr);
         acc_cyc.push_back(cyc);
      end
      if (inst_valid && inst_ready) begin
         pop_pc_log.push_back(inst_pc);
         pop_data_log.push_back(inst_data);
      end
      pend2      = req_valid2;
      pend2_addr = req_addr2;
      if (req_valid2) acc2_log.push_back(req_addr2);

      acc = exp_rv && imem_req_ready;
      pop = exp_iv && inst_ready;
      if (imem_rsp_valid) begin
         a = mem_addr.pop_front();
         void'(mem_due.pop_front());
         if (m_stale > 0) m_stale--;
         else if (!redirect_valid) begin
            buf_pc.push_back(a);
            buf_data.push_back(mem_word(a));
         end
      end
      if (pop) begin
         void'(buf_pc.pop_front());
         void'(buf_data.pop_front());
      end
      if (redirect_valid) begin
         buf_pc.delete();
         buf_data.delete();
         m_stale = mem_addr.size();
         m_pc    = {redirect_pc[31:2], 2'b00};
      end else if (acc) begin
         mem_addr.push_back(m_pc);
         mem_due.push_back(cyc + 1 + longint'($urandom_range(lat_max - 1)));
         m_pc = m_pc + 32'd4;
      end
      m_boot = 0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      reset = 1'b1;
      force_redir = 0;
      force_pc = 0;
      drive_idle();
      clear_model();
      @(posedge clk);
      #1;

      // Sequential fetch, 1-cycle memory, decode always ready.
      apply_reset();
      knobs(100, 100, 0, 100, 1);
      repeat (20) step();
      chk("a_acc_count", acc_log.size() >= 3, 1);
      chk("a_pop_count", pop_pc_log.size() >= 3, 1);
      if (acc_log.size() >= 3) begin
         chk("a_acc0", acc_log[0], 32'h0);
         chk("a_acc1", acc_log[1], 32'h4);
         chk("a_acc2", acc_log[2], 32'h8);
         chk("a_boot_cycle", 32'(acc_cyc[0]), 32'd1);
         chk("a_second_cycle", 32'(acc_cyc[1]), 32'd2);
      end
      if (pop_pc_log.size() >= 3) begin
         chk("a_pop_pc0", pop_pc_log[0], 32'h0);
         chk("a_pop_pc1", pop_pc_log[1], 32'h4);
         chk("a_pop_pc2", pop_pc_log[2], 32'h8);
         chk("a_pop_d0", pop_data_log[0], 32'hC0DE_5A5A);
         chk("a_pop_d1", pop_data_log[1], 32'hC0DA_5A5A);
         chk("a_pop_d2", pop_data_log[2], 32'hC0D6_5A5A);
      end
      chk("w_acc_count", acc2_log.size() >= 3, 1);
      if (acc2_log.size() >= 3) begin
         chk("w_acc0", acc2_log[0], 32'hFFFF_FFF8);
         chk("w_acc1", acc2_log[1], 32'hFFFF_FFFC);
         chk("w_acc2", acc2_log[2], 32'h0000_0000);
      end

      // Decode stalled: credits run out after two requests, one pop frees one.
      apply_reset();
      knobs(100, 0, 0, 100, 1);
      repeat (12) step();
      chk("b_acc_stall", acc_log.size(), 2);
      p_iready = 100;
      step();
      p_iready = 0;
      repeat (4) step();
      chk("b_acc_after_pop", acc_log.size(), 3);

      // Redirect with two requests outstanding.
      apply_reset();
      knobs(100, 100, 0, 0, 1);
      repeat (3) step();
      chk("c_inflight", acc_log.size(), 2);
      force_redir = 1;
      force_pc = 32'h0000_0103;
      step();
      force_redir = 0;
      p_rsp = 100;
      repeat (12) step();
      chk("c_acc_count", acc_log.size() >= 3, 1);
      chk("c_pop_count", pop_pc_log.size() >= 2, 1);
      if (acc_log.size() >= 3) chk("c_acc_redir", acc_log[2], 32'h0000_0100);
      if (pop_pc_log.size() >= 2) begin
         chk("c_pop0", pop_pc_log[0], 32'h0000_0100);
         chk("c_pop1", pop_pc_log[1], 32'h0000_0104);
      end

      // Randomized traffic, each round ending in a reset with a full buffer.
      for (int r = 0; r < 8; r++) begin
         apply_reset();
         knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
               int'($urandom_range(10)), int'($urandom_range(100, 30)),
               int'($urandom_range(4, 1)));
         repeat (300) step();
         knobs(100, 0, 0, 100, 1);
         repeat (10) step();
         apply_reset();
         knobs(100, 100, 0, 100, 2);
         repeat (4) step();
         chk("d_restart_count", acc_log.size() >= 1, 1);
         if (acc_log.size() >= 1) chk("d_restart_pc", acc_log[0], RST_PC);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
